uart_rx: RTL
============

Name: uart_rx

Overview:
Serial receiver that pairs with the UART transmitter. It consumes the transmitter's serial line and reassembles frames: start bit, DataBits data bits LSB first, optional parity bit, and StopBits stop bits. The recovered word goes to the consumer over a valid/ready handshake, with per-word parity and framing status. It uses the same bit-period model as the transmitter: one bit lasts ClockDivider clk cycles.

Parameters:
ClockDivider, 8, clk cycles per bit (>= 4)
DataBits, 8, data bits per frame, range [5,9]
StopBits, 1, stop bits, 1 or 2
Parity, 0, 0 = none, 1 = even (parity bit = ^data), 2 = odd (parity bit = ~^data)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_bit  input  1  serial line, asynchronous to clk, idles high
data_out  output  DataBits  received word
data_out_valid  output  1  data_out and status are valid
data_out_ready  input  1  consumer accepts the word when high together with valid
parity_error  output  1  parity mismatch for the presented word; 0 when Parity == 0
frame_error  output  1  a stop bit was sampled low for the presented word

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - data_out = 0, data_out_valid = 0, parity_error = 0, frame_error = 0.
  - Synchronizer flops = 1; FSM = IDLE.
- Synchronizer: in_bit passes through a 2-flop synchronizer. All logic uses the synchronized line (rx). Edge detection compares rx with its previous value.
- Parameter checks: elaboration-time $error for out-of-range parameters.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: an rx 1->0 transition (detect cycle = cycle 0) -> START with the counter cleared.
  - START: sample at cycle ClockDivider/2 (integer division). If rx = 1, it is a false start -> IDLE. Otherwise -> DATA.
  - DATA: sample every ClockDivider cycles. The sample for bit k (k = 0..DataBits-1) lands at ClockDivider/2 + (k+1)*ClockDivider. Samples shift in LSB first. After the last data bit -> PARITY if Parity != 0, else STOP.
  - PARITY: one sample. Compute the error as a mismatch against the expected parity bit for the received data.
  - STOP: StopBits samples at one-bit spacing. Any low sample sets the frame error. After the last stop sample -> IDLE. A start bit arriving immediately afterwards is detected normally, with no dead time beyond the edge detection.
- Delivery, in the cycle after the last stop sample:
  - If the output slot is free, or is being accepted that same cycle: load data_out/parity_error/frame_error and set data_out_valid.
  - If valid is high and ready is low: discard the new frame and leave the held word and status unchanged.
- Handshake:
  - valid stays high, and data/status stay stable, until the cycle where data_out_ready = 1.
  - valid drops the next cycle unless a new word loads in that same cycle.
- Latency: raw in_bit falling edge -> data_out_valid high = 2 + ClockDivider/2 + (TotalBits-1)*ClockDivider + 1 cycles, where TotalBits = 1 + DataBits + ParityBits + StopBits. For 8N1 at ClockDivider 8 this is 79.
- Break (line held low): received as data 0 with frame_error = 1. The receiver then waits in IDLE for a 1->0 edge; it does not re-trigger while the line stays low.
- Reset mid-frame: the frame is abandoned, no output is produced, and the first falling edge after rst deasserts is treated as a start.

Optional Feature:
UART_RX_OVERRUN_EN
- Defined: adds output port overrun (1 bit, reset 0). It is a sticky flag set when a completed frame is discarded because the slot is full. It clears only on reset.
- Undefined: no port is added and discards are silent.

Decomposition:
- Package uart_pkg:
  - Parity encoding constants PARITY_NONE/EVEN/ODD.
  - Function total_bits(DataBits, StopBits, Parity).
  - Function parity_bit(data, Parity), shared with the transmitter's frame builder.
  - rx state enum typedef.
- Sub-module sync_2ff: 2-flop synchronizer with a reset value parameter (here 1). It is reusable for other async inputs.

Test Plan:
- Loopback: uart_tx -> uart_rx, 8N1, ClockDivider 8, bytes 0x00, 0xA5, 0xFF, 0x3C sent back-to-back with ready tied high -> four valid pulses with matching data, no errors, first valid 79 cycles after the tx start edge.
- Parity: Parity = 1; drive 0x07 with parity bit 0 -> data_out = 0x07, parity_error = 1. Same test with Parity = 2 and the correct odd bit -> parity_error = 0.
- False start: 2-cycle low glitch on idle line, ClockDivider 8 -> no valid, FSM back in IDLE. A following valid 0x55 frame is received correctly.
- Framing/break: 0x81 with stop bit 0 -> frame_error = 1, data 0x81. Line held low for 30 bit times -> exactly one word 0x00 with frame_error = 1, then the next proper frame is received.
- Backpressure: ready low while 0x11 then 0x22 are received -> 0x11 held stable, 0x22 dropped, overrun = 1 (with UART_RX_OVERRUN_EN). Ready pulse in the same cycle as a completion -> new word loads and valid stays high.
- Reset mid-frame: assert rst during data bit 3 of 0xF0 -> outputs return to reset values, no valid. The next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame-size and parity helpers, and the receiver state type.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int total_bits(int data_bits, int stop_bits, int parity);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Data must be zero-extended; the padding does not disturb the reduction.
    function automatic logic parity_bit(logic [8:0] data, int parity);
        return (parity == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input, with a configurable reset value.
module sync_2ff #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= ResetValue;
            q    <= ResetValue;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART frame receiver with valid/ready output and parity/framing status.
// Define UART_RX_OVERRUN_EN to add a sticky overrun flag for frames dropped while the output slot is full.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockDivider = 8,
    parameter int DataBits     = 8,
    parameter int StopBits     = 1,
    parameter int Parity       = PARITY_NONE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    output logic [DataBits-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                parity_error,
`ifdef UART_RX_OVERRUN_EN
    output logic                overrun,
`endif
    output logic                frame_error
);

    localparam int CW = $clog2(ClockDivider + 1);

    if (ClockDivider < 4 || DataBits < 5 || DataBits > 9 || StopBits < 1 || StopBits > 2 ||
        Parity < 0 || Parity > 2) begin : g_bad_params
        $error("uart_rx: parameter out of range");
    end

    rx_state_t           state;
    logic                rx;
    logic                rx_prev;
    logic                tick;
    logic                done;
    logic                par_err;
    logic                frm_err;
    logic [CW-1:0]       cnt;
    logic [3:0]          idx;
    logic [DataBits-1:0] shreg;

    sync_2ff #(.ResetValue(1'b1)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in_bit),
        .q  (rx)
    );

    // cnt holds the cycle index within the current bit, so a full bit elapses when it reaches ClockDivider.
    assign tick = cnt == CW'(ClockDivider);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RX_IDLE;
            rx_prev        <= 1'b1;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            par_err        <= 1'b0;
            frm_err        <= 1'b0;
            done           <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            parity_error   <= 1'b0;
            frame_error    <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
            overrun        <= 1'b0;
`endif
        end else begin
            rx_prev <= rx;
            done    <= 1'b0;
            cnt     <= cnt + 1'b1;
            case (state)
                RX_IDLE: if (rx_prev && !rx) begin
                    state   <= RX_START;
                    cnt     <= CW'(1);
                    idx     <= '0;
                    par_err <= 1'b0;
                    frm_err <= 1'b0;
                end
                RX_START: if (cnt == CW'(ClockDivider / 2)) begin
                    cnt   <= CW'(1);
                    state <= rx ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (tick) begin
                    cnt   <= CW'(1);
                    shreg <= {rx, shreg[DataBits-1:1]};
                    idx   <= idx + 1'b1;
                    if (idx == 4'(DataBits - 1)) begin
                        idx   <= '0;
                        state <= (Parity != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: if (tick) begin
                    cnt     <= CW'(1);
                    par_err <= rx != parity_bit(9'(shreg), Parity);
                    state   <= RX_STOP;
                end
                RX_STOP: if (tick) begin
                    cnt     <= CW'(1);
                    frm_err <= frm_err | !rx;
                    idx     <= idx + 1'b1;
                    if (idx == 4'(StopBits - 1)) begin
                        idx   <= '0;
                        state <= RX_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
            // A finished frame only lands if the slot is empty or being emptied this cycle.
            if (done && (!data_out_valid || data_out_ready)) begin
                data_out       <= shreg;
                parity_error   <= par_err;
                frame_error    <= frm_err;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
`ifdef UART_RX_OVERRUN_EN
            if (done && data_out_valid && !data_out_ready) overrun <= 1'b1;
`endif
        end
    end

endmodule
